// File: rtl/ascii_capture_upload_pkg.sv
// Shared types and constants for the UK101 ASCII capture/upload path.
package uk101_pkg;

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_UPLOAD,
    S_CLEAR
  } cap_state_t;

  // Source of the upload read data; registered so ioctl_din is glitch-free
  // and can be forced to zero asynchronously by reset.
  typedef enum logic [1:0] {
    DIN_ZERO,
    DIN_PAD,
    DIN_RAM
  } din_sel_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_SUB = 8'h1A;

endpackage

// File: rtl/ascii_capture_upload_if.sv
// hps_io ioctl upload channel as seen by the capture block.
// master = HPS side, slave = ascii_capture_upload.
interface ascii_capture_upload_if;

  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_upload_req
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_upload_req
  );

endinterface

// File: rtl/ascii_capture_upload_ram.sv
// capture_ram: simple-dual-port byte buffer, one write port, one registered
// read port. No reset so it maps onto a block RAM.
module capture_ram #(
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  // Write port, driven by the capture side.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; rdata holds between read enables.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ascii_capture_upload.sv
// ascii_capture_upload: captures the UK101 ACIA TX byte stream into a linear
// buffer and serves it to the HPS over the ioctl upload channel.
// Optional build macro CAPTURE_AUTOREQ_EN: request an upload once capture has
// been idle for IDLE_CYCLES clocks.
module ascii_capture_upload
  import uk101_pkg::*;
#(
  parameter int         DEPTH_LOG2  = 13,
  parameter logic [7:0] PAD_BYTE    = ASCII_SUB,
  parameter int         IDLE_CYCLES = 48000000
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [7:0]            cap_data,
  input  logic                  cap_valid,
  input  logic                  cap_enable,
  input  logic                  clear,
  ascii_capture_upload_if.slave ioctl,
  output logic [DEPTH_LOG2:0]   cap_count,
  output logic                  cap_full,
  output logic                  cap_overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2+1)'(1);

  cap_state_t state, next_state;
  din_sel_t   din_sel;
  logic       upload_q;
  logic       upload_rise, upload_fall;
  logic       cap_hit, accept, overflow_set, zero_buf, rd_en, in_range;
  logic [7:0] ram_rdata;

  assign upload_rise = ioctl.ioctl_upload & ~upload_q;
  assign upload_fall = ~ioctl.ioctl_upload & upload_q;
  assign cap_full    = (cap_count == FULL_COUNT);
  assign cap_hit     = cap_valid & cap_enable & (cap_data != ASCII_NUL);
  assign in_range    = (ioctl.ioctl_addr < 16'(cap_count));

  // State register plus the delayed ioctl_upload used for edge detection.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_CAPTURE;
      upload_q <= 1'b0;
    end else begin
      state    <= next_state;
      upload_q <= ioctl.ioctl_upload;
    end
  end

  // Next state: upload start freezes the buffer, upload end consumes it.
  always_comb begin
    next_state = state;
    case (state)
      S_CAPTURE: if (upload_rise) next_state = S_UPLOAD;
      S_UPLOAD:  if (upload_fall) next_state = S_CLEAR;
      S_CLEAR:   next_state = S_CAPTURE;
      default:   next_state = S_CAPTURE;
    endcase
  end

  // FSM outputs: clear beats a simultaneous strobe, capture only in S_CAPTURE.
  always_comb begin
    accept       = 1'b0;
    overflow_set = 1'b0;
    zero_buf     = 1'b0;
    rd_en        = 1'b0;
    case (state)
      S_CAPTURE: begin
        zero_buf     = clear;
        accept       = cap_hit & ~cap_full & ~clear;
        overflow_set = cap_hit & cap_full & ~clear;
      end
      S_UPLOAD: rd_en = ioctl.ioctl_rd;
      S_CLEAR:  zero_buf = 1'b1;
      default:  zero_buf = 1'b0;
    endcase
  end

  // Fill level and sticky overflow; the write pointer is the count itself.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cap_count    <= '0;
      cap_overflow <= 1'b0;
    end else if (zero_buf) begin
      cap_count    <= '0;
      cap_overflow <= 1'b0;
    end else begin
      if (accept)       cap_count    <= cap_count + COUNT_ONE;
      if (overflow_set) cap_overflow <= 1'b1;
    end
  end

  capture_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (cap_count[DEPTH_LOG2-1:0]),
    .wdata (cap_data),
    .re    (rd_en),
    .raddr (ioctl.ioctl_addr[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata)
  );

  // Read-data source chosen on each ioctl_rd, lined up with the RAM latency.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      din_sel <= DIN_ZERO;
    end else if (ioctl.ioctl_rd) begin
      if (state != S_UPLOAD) din_sel <= DIN_ZERO;
      else if (in_range)     din_sel <= DIN_RAM;
      else                   din_sel <= DIN_PAD;
    end
  end

  // Read data mux; every source is a register, so ioctl_din is registered.
  always_comb begin
    case (din_sel)
      DIN_RAM: ioctl.ioctl_din = ram_rdata;
      DIN_PAD: ioctl.ioctl_din = PAD_BYTE;
      default: ioctl.ioctl_din = 8'h00;
    endcase
  end

`ifdef CAPTURE_AUTOREQ_EN
  localparam int                IDLE_W    = $clog2(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_PEN  = IDLE_W'(IDLE_CYCLES - 2);

  logic [IDLE_W-1:0] idle_cnt;
  logic              upload_req_q;

  // Idle timer: restarts on each byte, saturates so it requests only once.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      idle_cnt     <= '0;
      upload_req_q <= 1'b0;
    end else begin
      upload_req_q <= 1'b0;
      if (accept) begin
        idle_cnt <= '0;
      end else if (state == S_CAPTURE && cap_count != '0 && idle_cnt != IDLE_LAST) begin
        idle_cnt     <= idle_cnt + IDLE_W'(1);
        upload_req_q <= (idle_cnt == IDLE_PEN);
      end
    end
  end

  assign ioctl.ioctl_upload_req = upload_req_q;
`else
  // Without the auto-request feature IDLE_CYCLES only exists for a common
  // parameter list; tie it off so it is visibly consumed.
  logic unused_idle_cfg;
  assign unused_idle_cfg        = (IDLE_CYCLES != 0);
  assign ioctl.ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_capture_upload.sv
// Self-checking bench for ascii_capture_upload (DEPTH_LOG2=4, IDLE_CYCLES=100).
// The reference model is a byte queue plus an overflow flag.
module tb_ascii_capture_upload;

  localparam int         CAP = 16;
  localparam logic [7:0] PAD = 8'h1A;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] cap_data;
  logic       cap_valid, cap_enable, clear;
  logic [4:0] cap_count;
  logic       cap_full, cap_overflow;

  ascii_capture_upload_if bus ();

  ascii_capture_upload #(
    .DEPTH_LOG2  (4),
    .PAD_BYTE    (PAD),
    .IDLE_CYCLES (100)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .cap_data     (cap_data),
    .cap_valid    (cap_valid),
    .cap_enable   (cap_enable),
    .clear        (clear),
    .ioctl        (bus.slave),
    .cap_count    (cap_count),
    .cap_full     (cap_full),
    .cap_overflow (cap_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];
  bit         model_ovf = 0;
  bit         model_upl = 0;

  function automatic logic [7:0] model_read(input int addr);
    if (addr < model_q.size()) return model_q[addr];
    return PAD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input bit en);
    cap_data   = d;
    cap_enable = en;
    cap_valid  = 1'b1;
    if (!model_upl && en && d != 8'h00 && !clear) begin
      if (model_q.size() < CAP) model_q.push_back(d);
      else model_ovf = 1;
    end
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic start_upload();
    bus.ioctl_upload = 1'b1;
    tick();
    model_upl = 1;
  endtask

  task automatic end_upload();
    bus.ioctl_upload = 1'b0;
    tick();
    tick();
    model_upl = 0;
    model_q.delete();
    model_ovf = 0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    d = bus.ioctl_din;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #1;
    checks++; if (cap_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", cap_count); end
    checks++; if (cap_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", cap_full); end
    checks++; if (cap_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", cap_overflow); end
    checks++; if (bus.ioctl_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_din got=%h exp=00", bus.ioctl_din); end
    checks++; if (bus.ioctl_upload_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", bus.ioctl_upload_req); end
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_text_capture();
    logic [7:0] txt [10] = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49, 8'h4E, 8'h54, 8'h0D, 8'h0A};
    logic [7:0] got;
    for (int i = 0; i < 10; i++) begin
      strobe(txt[i], 1'b1);
      if (i == 2 || i == 5 || i == 8) strobe(8'h00, 1'b1);
    end
    checks++; if (cap_count !== 5'(model_q.size())) begin errors++; $display("[TB] FAIL text_count got=%0d exp=%0d", cap_count, model_q.size()); end
    start_upload();
    for (int a = 0; a < 12; a++) begin
      do_read(16'(a), got);
      checks++; if (got !== model_read(a)) begin errors++; $display("[TB] FAIL text_read addr=%0d got=%h exp=%h", a, got, model_read(a)); end
    end
    tick();
    checks++; if (bus.ioctl_din !== model_read(11)) begin errors++; $display("[TB] FAIL text_hold got=%h exp=%h", bus.ioctl_din, model_read(11)); end
    end_upload();
    checks++; if (cap_count !== 5'd0) begin errors++; $display("[TB] FAIL text_consumed got=%0d exp=0", cap_count); end
  endtask

  task automatic test_disabled();
    logic [7:0] got;
    for (int i = 0; i < 5; i++) strobe(8'(8'h41 + i), 1'b0);
    checks++; if (cap_count !== 5'd0) begin errors++; $display("[TB] FAIL disabled_count got=%0d exp=0", cap_count); end
    start_upload();
    do_read(16'd0, got);
    checks++; if (got !== model_read(0)) begin errors++; $display("[TB] FAIL disabled_read got=%h exp=%h", got, model_read(0)); end
    end_upload();
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    for (int i = 0; i < 17; i++) strobe(8'(8'h60 + i), 1'b1);
    checks++; if (cap_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got=%0d exp=16", cap_count); end
    checks++; if (cap_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got=%b exp=1", cap_full); end
    checks++; if (cap_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=%b", cap_overflow, model_ovf); end
    start_upload();
    do_read(16'd15, got);
    checks++; if (got !== model_read(15)) begin errors++; $display("[TB] FAIL ovf_last got=%h exp=%h", got, model_read(15)); end
    do_read(16'd16, got);
    checks++; if (got !== PAD) begin errors++; $display("[TB] FAIL ovf_pad16 got=%h exp=%h", got, PAD); end
    do_read(16'h0013, got);
    checks++; if (got !== PAD) begin errors++; $display("[TB] FAIL ovf_alias got=%h exp=%h", got, PAD); end
    end_upload();
    checks++; if (cap_full !== 1'b0 || cap_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared full=%b ovf=%b exp=0,0", cap_full, cap_overflow); end
  endtask

  task automatic test_upload_drop();
    logic [7:0] got;
    for (int i = 0; i < 3; i++) strobe(8'(8'h70 + i), 1'b1);
    start_upload();
    strobe(8'h55, 1'b1);
    strobe(8'h56, 1'b1);
    checks++; if (cap_count !== 5'd3) begin errors++; $display("[TB] FAIL drop_count got=%0d exp=3", cap_count); end
    checks++; if (cap_overflow !== 1'b0) begin errors++; $display("[TB] FAIL drop_ovf got=%b exp=0", cap_overflow); end
    do_read(16'd3, got);
    checks++; if (got !== model_read(3)) begin errors++; $display("[TB] FAIL drop_read got=%h exp=%h", got, model_read(3)); end
    end_upload();
    checks++; if (cap_count !== 5'd0) begin errors++; $display("[TB] FAIL drop_consumed got=%0d exp=0", cap_count); end
  endtask

  task automatic test_clear();
    logic [7:0] got;
    for (int i = 0; i < 4; i++) strobe(8'(8'h30 + i), 1'b1);
    clear = 1'b1;
    model_q.delete();
    model_ovf = 0;
    strobe(8'h7A, 1'b1);
    clear = 1'b0;
    checks++; if (cap_count !== 5'd0) begin errors++; $display("[TB] FAIL clear_count got=%0d exp=0", cap_count); end
    strobe(8'h42, 1'b1);
    strobe(8'h43, 1'b1);
    start_upload();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (cap_count !== 5'd2) begin errors++; $display("[TB] FAIL clear_in_upload got=%0d exp=2", cap_count); end
    do_read(16'd0, got);
    checks++; if (got !== model_read(0)) begin errors++; $display("[TB] FAIL clear_not_stored got=%h exp=%h", got, model_read(0)); end
    end_upload();
  endtask

  task automatic test_rd_outside();
    logic [7:0] got;
    strobe(8'h44, 1'b1);
    do_read(16'd0, got);
    checks++; if (got !== 8'h00) begin errors++; $display("[TB] FAIL rd_outside got=%h exp=00", got); end
  endtask

  task automatic test_reset_mid_upload();
    logic [7:0] got;
    strobe(8'h21, 1'b1);
    strobe(8'h22, 1'b1);
    start_upload();
    do_read(16'd1, got);
    checks++; if (got !== model_read(1)) begin errors++; $display("[TB] FAIL midrst_pre got=%h exp=%h", got, model_read(1)); end
    n_reset = 1'b0;
    #1;
    checks++; if (bus.ioctl_din !== 8'h00) begin errors++; $display("[TB] FAIL midrst_din got=%h exp=00", bus.ioctl_din); end
    checks++; if (cap_count !== 5'd0) begin errors++; $display("[TB] FAIL midrst_count got=%0d exp=0", cap_count); end
    bus.ioctl_upload = 1'b0;
    tick();
    n_reset = 1'b1;
    model_upl = 0;
    model_q.delete();
    model_ovf = 0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] got;
    logic [7:0] d;
    int         n, a;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 22);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          clear = 1'b1;
          model_q.delete();
          model_ovf = 0;
          tick();
          clear = 1'b0;
        end
        d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        strobe(d, $urandom_range(0, 4) != 0);
      end
      checks++; if (cap_count !== 5'(model_q.size())) begin errors++; $display("[TB] FAIL rnd_count round=%0d got=%0d exp=%0d", r, cap_count, model_q.size()); end
      checks++; if (cap_full !== (model_q.size() == CAP)) begin errors++; $display("[TB] FAIL rnd_full round=%0d got=%b", r, cap_full); end
      checks++; if (cap_overflow !== model_ovf) begin errors++; $display("[TB] FAIL rnd_ovf round=%0d got=%b exp=%b", r, cap_overflow, model_ovf); end
      start_upload();
      for (int k = 0; k < 10; k++) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 18);
        do_read(16'(a), got);
        checks++; if (got !== model_read(a)) begin errors++; $display("[TB] FAIL rnd_read round=%0d addr=%0d got=%h exp=%h", r, a, got, model_read(a)); end
      end
      end_upload();
    end
  endtask

  task automatic test_autoreq();
    int pulses = 0;
    int first  = -1;
    strobe(8'h58, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
`ifdef CAPTURE_AUTOREQ_EN
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL autoreq_pulses got=%0d exp=1", pulses); end
    checks++; if (first !== 99) begin errors++; $display("[TB] FAIL autoreq_time got=%0d exp=99", first); end
`else
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL autoreq_off got=%0d exp=0 (first=%0d)", pulses, first); end
`endif
  endtask

  initial begin
    n_reset          = 1'b0;
    cap_data         = 8'h00;
    cap_valid        = 1'b0;
    cap_enable       = 1'b1;
    clear            = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 16'h0000;
    test_reset();
    test_text_capture();
    test_disabled();
    test_overflow();
    test_upload_drop();
    test_clear();
    test_rd_outside();
    test_reset_mid_upload();
    test_random();
    test_autoreq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
